sub_unit_arbiter: RTL and testbench
===================================

// Module: sub_unit_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer sharing one sign-magnitude subtractor (subUnit) among NREQ requesters.
//  Sits between the lane/issue logic and the single subUnit instance; owns operand latching and response return.
//  Valid/ready handshake on both sides; one operation in flight; result and flags registered.
// PARAMETERS
//  N     32                   data width of operands/result (subUnit width)
//  NREQ  4                    number of requesters (>=2)
//  IDW   $clog2(NREQ)         width of requester id (derived, do not override)
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         synchronous reset, active-high
//  req_valid  in   NREQ      per-requester op request
//  req_a      in   NREQ*N    operand A, requester i at [i*N +: N]
//  req_b      in   NREQ*N    operand B, same packing
//  req_ready  out  NREQ      one-hot accept; transfer when req_valid[i] & req_ready[i]
//  rsp_valid  out  1         result available
//  rsp_ready  in   1         consumer accepts result
//  rsp_id     out  IDW       requester index owning result
//  rsp_c      out  N         result (subUnit c)
//  rsp_zero   out  1         subUnit zero
//  rsp_neg    out  1         subUnit neg
//  rsp_cout   out  1         subUnit cout
// BEHAVIOUR
//  FSM: IDLE -> EXEC -> RESP -> IDLE.
//  IDLE: grant = first i with req_valid[i], searching ptr, ptr+1, ... mod NREQ; req_ready = onehot(grant)
//   combinationally, only in IDLE; on transfer latch a, b, id; go EXEC. No valid -> stay, req_ready=0.
//  EXEC: latched a, b drive subUnit; its c/zero/neg/cout captured into rsp_* regs; go RESP.
//  RESP: rsp_valid=1; rsp_* held stable until rsp_ready; on rsp_valid&rsp_ready: rsp_valid=0 next cycle,
//   ptr <= (id+1) mod NREQ, go IDLE.
//  Latency: accept at edge T -> rsp_valid high after edge T+2; min issue interval 3 cycles.
//  req_ready=0 in EXEC and RESP; requesters hold valid+operands until accepted; dropping valid before accept is legal.
//  Arithmetic is exactly subUnit: sign-magnitude on bits [15:0] (bit15 sign, [14:0] magnitude), input bits [N-1:16]
//   ignored, rsp_c[N-1:16]=0; same signs -> 16-bit a_mag-b_mag (wraps, no re-negation), differing signs -> sum;
//   overflow not exported (always 0 in subUnit).
//  Reset (any state, incl. mid-op): state=IDLE, ptr=0, rsp_valid=0, rsp_id=0, rsp_c=0, flags=0, req_ready=0
//   in reset cycle; in-flight op discarded, no response emitted.
//  rsp_ready high outside RESP: ignored. ptr wraps NREQ-1 -> 0.
// CONFIGURATION
//  SUB_ARB_STATS_EN defined: extra output grant_cnt [NREQ*16-1:0]; field i at [i*16 +: 16] counts
//   accepted requests of requester i, saturates at 16'hFFFF, cleared by rst.
//  Undefined: grant_cnt port and counters absent; all other behaviour identical.
// TESTING
//  rst, req_valid=0 for 5 cycles -> req_ready=0, rsp_valid=0, rsp_c=0.
//  req0 a=0x0005 b=0x0003 -> accept T, rsp_valid at T+2, rsp_id=0, rsp_c=0x00000002, zero=0 neg=0 cout=0.
//  req1 a=0x0003 b=0x0005 -> rsp_c=0x0000FFFE, neg=1, cout=1, zero=0; a=0x8004 b=0x0004 -> rsp_c=0x00008008, neg=1.
//  all 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; one accept per 3 cycles.
//  rsp_ready=0 for 4 cycles in RESP -> rsp_* stable, req_ready=0; then rsp_ready=1 -> next grant follows ptr.
//  rst asserted during EXEC -> no rsp_valid; after release req2 granted first only if req0/req1 idle (ptr=0).
//  SUB_ARB_STATS_EN: 3 ops from req2 -> grant_cnt[47:32]=3, others 0; rst clears.

Source files
------------

// File: rtl/sub_unit_arbiter.sv
// Round-robin arbiter sequencing NREQ requesters onto one shared sign-magnitude subtractor.
// Define SUB_ARB_STATS_EN to add the per-requester grant_cnt output.

module sub_unit #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] c,
   output logic         zero,
   output logic         neg,
   output logic         cout
);
   logic        sign_a;
   logic        sign_b;
   logic [15:0] mag_a;
   logic [15:0] mag_b;
   logic [15:0] diff;
   logic [15:0] sum;
   logic        unused_hi;

   // Only the low 16 bits carry a sign-magnitude operand; the upper bits are ignored.
   assign unused_hi = ^{a[N-1:16], b[N-1:16]};
   assign sign_a    = a[15];
   assign sign_b    = b[15];
   assign mag_a     = {1'b0, a[14:0]};
   assign mag_b     = {1'b0, b[14:0]};
   assign diff      = mag_a - mag_b;
   assign sum       = mag_a + mag_b;

   always_comb begin
      c    = '0;
      zero = 1'b0;
      neg  = 1'b0;
      cout = 1'b0;
      if (sign_a == sign_b) begin
         c[15:0] = diff;
         cout    = (mag_a < mag_b);
         neg     = sign_a ^ (mag_a < mag_b);
         zero    = (diff == 16'd0);
      end else begin
         c[15:0] = {sign_a, sum[14:0]};
         cout    = sum[15];
         neg     = sign_a;
         zero    = (sum[14:0] == 15'd0);
      end
   end
endmodule

module sub_unit_arbiter #(
   parameter int N    = 32,
   parameter int NREQ = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*N-1:0]        req_a,
   input  logic [NREQ*N-1:0]        req_b,
   output logic [NREQ-1:0]          req_ready,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [N-1:0]             rsp_c,
   output logic                     rsp_zero,
   output logic                     rsp_neg,
   output logic                     rsp_cout
`ifdef SUB_ARB_STATS_EN
   ,
   output logic [NREQ*16-1:0]       grant_cnt
`endif
);
   localparam int IDW = $clog2(NREQ);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [N-1:0]    a_q, a_d;
   logic [N-1:0]    b_q, b_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;
   logic [N-1:0]    rsp_c_q, rsp_c_d;
   logic            rsp_zero_q, rsp_zero_d;
   logic            rsp_neg_q, rsp_neg_d;
   logic            rsp_cout_q, rsp_cout_d;

   logic [N-1:0]    a_arr [NREQ];
   logic [N-1:0]    b_arr [NREQ];
   logic [IDW-1:0]  grant_idx;
   logic            grant_any;
   int              rr_idx;
   logic            accept;

   logic [N-1:0]    sub_c;
   logic            sub_zero;
   logic            sub_neg;
   logic            sub_cout;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign a_arr[gi] = req_a[gi*N +: N];
         assign b_arr[gi] = req_b[gi*N +: N];
      end
   endgenerate

   // Scan from farthest to nearest so the first valid at or after ptr wins.
   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      rr_idx    = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         rr_idx = (int'(ptr_q) + k) % NREQ;
         if (req_valid[rr_idx]) begin
            grant_idx = IDW'(rr_idx);
            grant_any = 1'b1;
         end
      end
   end

   assign accept = (state_q == S_IDLE) && grant_any && !rst;

   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   sub_unit #(.N(N)) u_sub (
      .a    (a_q),
      .b    (b_q),
      .c    (sub_c),
      .zero (sub_zero),
      .neg  (sub_neg),
      .cout (sub_cout)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      id_d       = id_q;
      a_d        = a_q;
      b_d        = b_q;
      rsp_id_d   = rsp_id_q;
      rsp_c_d    = rsp_c_q;
      rsp_zero_d = rsp_zero_q;
      rsp_neg_d  = rsp_neg_q;
      rsp_cout_d = rsp_cout_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               a_d     = a_arr[grant_idx];
               b_d     = b_arr[grant_idx];
               id_d    = grant_idx;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            rsp_c_d    = sub_c;
            rsp_zero_d = sub_zero;
            rsp_neg_d  = sub_neg;
            rsp_cout_d = sub_cout;
            rsp_id_d   = id_q;
            state_d    = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         id_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         rsp_id_q   <= '0;
         rsp_c_q    <= '0;
         rsp_zero_q <= 1'b0;
         rsp_neg_q  <= 1'b0;
         rsp_cout_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         id_q       <= id_d;
         a_q        <= a_d;
         b_q        <= b_d;
         rsp_id_q   <= rsp_id_d;
         rsp_c_q    <= rsp_c_d;
         rsp_zero_q <= rsp_zero_d;
         rsp_neg_q  <= rsp_neg_d;
         rsp_cout_q <= rsp_cout_d;
      end
   end

   assign rsp_valid = (state_q == S_RESP);
   assign rsp_id    = rsp_id_q;
   assign rsp_c     = rsp_c_q;
   assign rsp_zero  = rsp_zero_q;
   assign rsp_neg   = rsp_neg_q;
   assign rsp_cout  = rsp_cout_q;

`ifdef SUB_ARB_STATS_EN
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_stats
         logic [15:0] cnt_q, cnt_d;
         always_comb begin
            cnt_d = cnt_q;
            if (req_valid[gi] && req_ready[gi] && (cnt_q != 16'hFFFF)) begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
         assign grant_cnt[gi*16 +: 16] = cnt_q;
      end
   endgenerate
`endif
endmodule

// File: tb/tb_sub_unit_arbiter.sv
// Directed bench for sub_unit_arbiter: reset, arithmetic, round-robin order, back-pressure, mid-op reset.
// Grant-counter checks are active when SUB_ARB_STATS_EN is defined.

module tb_sub_unit_arbiter;
   localparam int N    = 32;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                clk;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*N-1:0]   req_a;
   logic [NREQ*N-1:0]   req_b;
   logic [NREQ-1:0]     req_ready;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [IDW-1:0]      rsp_id;
   logic [N-1:0]        rsp_c;
   logic                rsp_zero;
   logic                rsp_neg;
   logic                rsp_cout;
`ifdef SUB_ARB_STATS_EN
   logic [NREQ*16-1:0]  grant_cnt;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   sub_unit_arbiter #(.N(N), .NREQ(NREQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_c     (rsp_c),
      .rsp_zero  (rsp_zero),
      .rsp_neg   (rsp_neg),
      .rsp_cout  (rsp_cout)
`ifdef SUB_ARB_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One isolated transaction from requester idx; rsp_ready is held high.
   task automatic issue(input int idx, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] exp_c, input logic exp_z, input logic exp_n,
                        input logic exp_co);
      logic [NREQ-1:0] exp_rdy;
      exp_rdy = '0;
      exp_rdy[idx] = 1'b1;
      req_a[idx*N +: N] = a;
      req_b[idx*N +: N] = b;
      req_valid = exp_rdy;
      #1;
      check("issue_ready", req_ready, exp_rdy);
      step();
      req_valid = '0;
      #1;
      check("exec_rsp_valid", rsp_valid, 1'b0);
      check("exec_req_ready", req_ready, 4'b0000);
      step();
      check("resp_valid", rsp_valid, 1'b1);
      check("resp_id", rsp_id, idx[IDW-1:0]);
      check("resp_c", rsp_c, exp_c);
      check("resp_zero", rsp_zero, exp_z);
      check("resp_neg", rsp_neg, exp_n);
      check("resp_cout", rsp_cout, exp_co);
      $display("txn req%0d a=%h b=%h -> c=%h z=%b n=%b co=%b", idx, a, b, rsp_c, rsp_zero, rsp_neg, rsp_cout);
      step();
      check("post_rsp_valid", rsp_valid, 1'b0);
   endtask

   initial begin
      int order [5];
      logic [N-1:0] held_c;
      order = '{0, 1, 2, 3, 0};

      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;

      // Reset state
      repeat (5) step();
      check("rst_req_ready", req_ready, 4'b0000);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_c", rsp_c, 32'h0);
      check("rst_rsp_id", rsp_id, 2'd0);
      req_valid = 4'b1111;
      #1;
      check("rst_ready_gated", req_ready, 4'b0000);
      req_valid = '0;
      rst = 1'b0;
      step();

      // Arithmetic through isolated requests
      issue(0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
      issue(1, 32'h0000_0003, 32'h0000_0005, 32'h0000_FFFE, 1'b0, 1'b1, 1'b1);
      issue(1, 32'h0000_8004, 32'h0000_0004, 32'h0000_8008, 1'b0, 1'b1, 1'b0);
      issue(2, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
      issue(3, 32'hFFFF_0009, 32'h0000_0002, 32'h0000_0007, 1'b0, 1'b0, 1'b0);

      // All requesters valid: grants rotate 0,1,2,3,0 with one accept every 3 cycles
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*N +: N] = 32'(i + 10);
         req_b[i*N +: N] = 32'h1;
      end
      req_valid = 4'b1111;
      #1;
      for (int t = 0; t < 5; t++) begin
         check("rr_grant", req_ready, 4'b0001 << order[t]);
         step();
         check("rr_exec_ready", req_ready, 4'b0000);
         step();
         check("rr_resp_valid", rsp_valid, 1'b1);
         check("rr_resp_id", rsp_id, order[t][IDW-1:0]);
         check("rr_resp_c", rsp_c, 32'(order[t] + 9));
         $display("txn rr%0d grant=req%0d c=%h", t, rsp_id, rsp_c);
         step();
      end

      // Back-pressure in RESP: ptr is 1 after the last grant to req0
      rsp_ready = 1'b0;
      check("bp_grant", req_ready, 4'b0010);
      step();
      step();
      held_c = rsp_c;
      check("bp_first_c", held_c, 32'h0000_000A);
      for (int t = 0; t < 4; t++) begin
         check("bp_valid", rsp_valid, 1'b1);
         check("bp_c_stable", rsp_c, 32'h0000_000A);
         check("bp_id_stable", rsp_id, 2'd1);
         check("bp_req_ready", req_ready, 4'b0000);
         step();
      end
      rsp_ready = 1'b1;
      #1;
      step();
      check("bp_release_valid", rsp_valid, 1'b0);
      check("bp_next_grant", req_ready, 4'b0100);
      $display("txn bp req1 held 4 cycles c=%h, next grant=%b", held_c, req_ready);
      req_valid = '0;
      #1;

      // Reset during EXEC discards the op and returns ptr to 0
      req_valid = 4'b0100;
      #1;
      check("mid_grant", req_ready, 4'b0100);
      step();
      req_valid = '0;
      rst = 1'b1;
      #1;
      check("mid_rst_ready", req_ready, 4'b0000);
      step();
      check("mid_rst_valid", rsp_valid, 1'b0);
      rst = 1'b0;
      step();
      check("mid_after_valid0", rsp_valid, 1'b0);
      check("mid_after_c", rsp_c, 32'h0);
      step();
      check("mid_after_valid1", rsp_valid, 1'b0);
      req_valid = 4'b1010;
      #1;
      check("mid_ptr_zero", req_ready, 4'b0010);
      req_valid = 4'b1100;
      #1;
      check("mid_req2_first", req_ready, 4'b0100);
      $display("txn mid-op reset: no response, ptr restarted at 0");
      req_valid = '0;
      #1;

`ifdef SUB_ARB_STATS_EN
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      for (int t = 0; t < 3; t++) begin
         issue(2, 32'h0000_0004, 32'h0000_0001, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
      end
      check("cnt_req2", grant_cnt[47:32], 16'd3);
      check("cnt_req0", grant_cnt[15:0], 16'd0);
      check("cnt_req1", grant_cnt[31:16], 16'd0);
      check("cnt_req3", grant_cnt[63:48], 16'd0);
      $display("txn stats grant_cnt=%h", grant_cnt);
      rst = 1'b1;
      step();
      check("cnt_cleared", grant_cnt, 64'h0);
      rst = 1'b0;
      step();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
